integrator_channel_scheduler: RTL
=================================

Name: integrator_channel_scheduler

Overview:
- Time-multiplexes one saturating integrator datapath across N_CHANNELS control loops.
- Per-channel integral state is held in an internal register file.
- A round-robin arbiter grants one requester per cycle; the result is saturated against shared limits, written back, and emitted with its channel id.
- Sits between per-loop error generators and the downstream PI/PID sum stage; replaces N separate integrator instances.

Parameters:
- DATA_WIDTH, 16, signed width of errors, limits, state and output.
- N_CHANNELS, 4, number of requesters (≥2).
- CH_WIDTH, $clog2(N_CHANNELS), width of channel index.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  N_CHANNELS  per-channel request valid.
- req_ready  out  N_CHANNELS  per-channel accept (one-hot or zero).
- error_in  in  N_CHANNELS*DATA_WIDTH  packed signed errors; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- limit_int_up  in  DATA_WIDTH  signed upper saturation limit, shared by all channels.
- limit_int_down  in  DATA_WIDTH  signed lower saturation limit, shared by all channels.
- clear_all  in  1  pulse; re-initialises every channel state to 0.
- clear_ch_valid  in  1  pulse; clears a single channel.
- clear_ch  in  CH_WIDTH  channel index for clear_ch_valid.
- out_valid  out  1  result strobe, one cycle.
- out_channel  out  CH_WIDTH  channel of the result.
- out_data  out  DATA_WIDTH  new saturated integral state.
- out_sat  out  2  {hit_up, hit_down} saturation flags for this result.
- busy_init  out  1  high during the clear sweep.

Behaviour:
- Reset (reset=0 at posedge):
  - state ← INIT; sweep index ← 0; RR pointer ← 0.
  - out_valid, out_channel, out_data, out_sat ← 0.
  - Pipeline valid ← 0.
  - req_ready is 0 while in INIT.
- FSM:
  - INIT: writes 0 to state[sweep index], one channel per cycle; busy_init=1; req_ready=0.
  - After N_CHANNELS cycles, INIT → RUN.
  - RUN → INIT when clear_all=1, sweep restarting at 0. Any in-flight stage-1 operation completes and emits; its write-back is then overwritten by the sweep.
  - clear_all during INIT restarts the sweep at index 0.
- Arbitration (RUN only; req_ready is combinational from req_valid and the pointer):
  - Grant goes to the first asserted req_valid at or after the pointer, wrapping modulo N_CHANNELS.
  - On a handshake the pointer ← granted+1, wrapping N_CHANNELS-1 → 0.
  - With no valid requests, the pointer holds.
  - Requesters must hold req_valid and error_in until req_ready; no combinational ready-to-valid dependency.
- Pipeline, 1 op/cycle sustained:
  - Stage 0: on handshake at edge k, register channel and error.
  - Stage 1: combinationally read state[ch] and form sum = error + state in DATA_WIDTH+1 bits (no wrap).
    - sum > limit_int_up → limit_int_up, hit_up=1.
    - sum < limit_int_down → limit_int_down, hit_down=1.
    - Otherwise → sum.
  - At edge k+1, the result is written to state[ch] and registered to out_*; out_valid is high during the cycle after edge k+1. Latency = 2 edges from handshake.
  - Back-to-back updates of the same channel: the write at edge k+1 is visible to a stage-1 read at edge k+2. No stall or bypass is needed; results must equal serial evaluation.
- Limit misconfiguration: if limit_int_down > limit_int_up, the up check has priority.
- Single-channel clear (RUN):
  - clear_ch_valid writes 0 to state[clear_ch] at the next edge.
  - If stage 1 writes the same channel at the same edge, the clear wins.
  - out_valid is still emitted, carrying the computed value.
  - clear_ch ≥ N_CHANNELS is ignored.
- clear_ch_valid during INIT is ignored.

Decomposition:
- Package integrator_sched_pkg holds:
  - fsm_state_t enum {INIT, RUN}.
  - sat_flags_t packed struct {hit_up, hit_down}.
  - Function saturate(sum, up, down).
- Sub-module rr_arbiter #(N) holds the pointer register and grant logic, with ports clock, reset, request, advance, grant.

Test Plan:
- Reset, then hold all req_valid=1 → busy_init for 4 cycles, no ready; then grants 0,1,2,3,0 on consecutive cycles.
- Ch2 only, error=100 ×3, limits ±1000 → out_data 100, 200, 300 on consecutive cycles, each 2 edges after its handshake; out_channel=2.
- Ch1 error=600 ×2, up=1000 → 600, then 1000 with out_sat=2'b10. Then error=-32768, down=-1000 → -1000 with out_sat=2'b01 and no wrap at DATA_WIDTH=16.
- Same-edge clear_ch_valid=1, clear_ch=3 with a ch3 write-back → out_data shows the computed value; next ch3 error=5 gives out_data=5.
- clear_all mid-stream with ch0 state=400 → in-flight result emitted, busy_init for 4 cycles; next ch0 error=7 gives out_data=7.
- Requests on ch0 and ch3 only, pointer=1 → grant order 3,0,3,0; ch1 and ch2 never readied.

Source files
------------

// File: rtl/integrator_channel_scheduler_pkg.sv
// integrator_sched_pkg: shared FSM/saturation types and the saturating clamp helper
package integrator_sched_pkg;
  localparam int SAT_W = 32;
  typedef enum logic {INIT, RUN} fsm_state_t;
  typedef struct packed {
    logic hit_up;
    logic hit_down;
  } sat_flags_t;
  typedef struct packed {
    logic [SAT_W-1:0] value;
    sat_flags_t flags;
  } sat_result_t;
  function automatic sat_result_t saturate(
    input logic signed [SAT_W:0] sum,
    input logic signed [SAT_W-1:0] up,
    input logic signed [SAT_W-1:0] down
  );
    sat_result_t r;
    r.flags.hit_up = sum > (SAT_W+1)'(up);
    r.flags.hit_down = !r.flags.hit_up && sum < (SAT_W+1)'(down);
    r.value = r.flags.hit_up ? up : r.flags.hit_down ? down : sum[SAT_W-1:0];
    return r;
  endfunction
endpackage

// File: rtl/integrator_channel_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant starting at a rotating pointer
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] request,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int CW = $clog2(N);
  logic [CW-1:0] ptr, gidx;
  logic [N-1:0] masked;
  // lowest request at or above the pointer, else lowest overall (wrap)
  always_comb begin
    masked = request & ({N{1'b1}} << ptr);
    grant = |masked ? masked & (~masked + 1'b1) : request & (~request + 1'b1);
    gidx = '0;
    for (int i = 0; i < N; i++) if (grant[i]) gidx = CW'(i);
  end
  // pointer moves just past the granted requester on each accepted grant
  always_ff @(posedge clock)
    ptr <= !reset ? '0 : advance ? (gidx == CW'(N-1) ? '0 : gidx + 1'b1) : ptr;
endmodule

// File: rtl/integrator_channel_scheduler.sv
// integrator_channel_scheduler: one saturating integrator shared round-robin across N channels
module integrator_channel_scheduler
  import integrator_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_CHANNELS = 4,
  parameter int CH_WIDTH   = $clog2(N_CHANNELS)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_CHANNELS-1:0]            req_valid,
  output logic [N_CHANNELS-1:0]            req_ready,
  input  logic [N_CHANNELS*DATA_WIDTH-1:0] error_in,
  input  logic signed [DATA_WIDTH-1:0]     limit_int_up,
  input  logic signed [DATA_WIDTH-1:0]     limit_int_down,
  input  logic                             clear_all,
  input  logic                             clear_ch_valid,
  input  logic [CH_WIDTH-1:0]              clear_ch,
  output logic                             out_valid,
  output logic [CH_WIDTH-1:0]              out_channel,
  output logic signed [DATA_WIDTH-1:0]     out_data,
  output logic [1:0]                       out_sat,
  output logic                             busy_init
);
  fsm_state_t state;
  logic [CH_WIDTH-1:0] sweep, gidx, s0_ch;
  logic s0_valid, run, take;
  logic signed [DATA_WIDTH-1:0] s0_err;
  logic signed [DATA_WIDTH-1:0] mem [2**CH_WIDTH];
  logic signed [DATA_WIDTH:0] sum;
  sat_result_t res;
  logic [N_CHANNELS-1:0] grant;
  assign run = state == RUN;
  assign take = run && |req_valid;
  assign req_ready = run ? grant : '0;
  assign busy_init = !run;
  rr_arbiter #(.N(N_CHANNELS)) u_arb (
    .clock(clock),
    .reset(reset),
    .request(req_valid),
    .advance(take),
    .grant(grant)
  );
  // grant index and stage-1 integrate/clamp against the live register file
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CHANNELS; i++) if (grant[i]) gidx = CH_WIDTH'(i);
    sum = (DATA_WIDTH+1)'(s0_err) + (DATA_WIDTH+1)'(mem[s0_ch]);
    res = saturate((SAT_W+1)'(sum), SAT_W'(limit_int_up), SAT_W'(limit_int_down));
  end
  // control FSM, stage-0 capture and registered result outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= INIT;
      sweep <= '0;
      s0_valid <= 1'b0;
      out_valid <= 1'b0;
      out_channel <= '0;
      out_data <= '0;
      out_sat <= '0;
    end else begin
      s0_valid <= take;
      if (take) begin
        s0_ch <= gidx;
        s0_err <= error_in[gidx*DATA_WIDTH +: DATA_WIDTH];
      end
      out_valid <= s0_valid;
      if (s0_valid) begin
        out_channel <= s0_ch;
        out_data <= res.value[DATA_WIDTH-1:0];
        out_sat <= res.flags;
      end
      if (clear_all) begin
        state <= INIT;
        sweep <= '0;
      end else if (!run) begin
        state <= sweep == CH_WIDTH'(N_CHANNELS-1) ? RUN : INIT;
        sweep <= sweep == CH_WIDTH'(N_CHANNELS-1) ? '0 : sweep + 1'b1;
      end
    end
  end
  // write-back first so a same-edge single clear or sweep clear overrides it
  always_ff @(posedge clock) begin
    if (reset) begin
      if (s0_valid) mem[s0_ch] <= res.value[DATA_WIDTH-1:0];
      if (run && clear_ch_valid) mem[clear_ch] <= '0;
      if (!run) mem[sweep] <= '0;
    end
  end
endmodule
